// File: rtl/lifo_arb_if.sv
// lifo_arb_if: requester-side bundle for lifo_arb.
// Carries push/pop requests, grants, pop responses, flush handshake and
// occupancy status. The arbiter uses the slave modport, requesters the master.
interface lifo_arb_if #(
    parameter int DATA_W  = 10,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 4
);
    logic [NUM_REQ-1:0]        req_push;
    logic [NUM_REQ-1:0]        req_pop;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        grant;
    logic                      flush;
    logic                      flush_done;
    logic                      rsp_valid;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_data;
    logic [CNT_W-1:0]          count;
    logic                      full;
    logic                      empty;

    modport master (
        output req_push, req_pop, req_data, flush,
        input  grant, flush_done, rsp_valid, rsp_id, rsp_data, count, full, empty
    );

    modport slave (
        input  req_push, req_pop, req_data, flush,
        output grant, flush_done, rsp_valid, rsp_id, rsp_data, count, full, empty
    );
endinterface

// File: rtl/lifo_arb.sv
// lifo_arb: round-robin arbiter sharing one LIFO stack among NUM_REQ requesters.
// One stack operation per cycle; occupancy tracking keeps pushes off a full
// stack and pops off an empty one. Pop data returns one cycle after the grant,
// tagged with the requester id. A flush pulse drains the stack.
// Optional macro LIFO_ARB_STATS_EN adds 16-bit saturating push/pop/stall counters.
module lifo_arb #(
    parameter int DATA_W    = 10,
    parameter int LIFO_SIZE = 6,
    parameter int NUM_REQ   = 4,
    parameter int ID_W      = 2,
    parameter int CNT_W     = 4
) (
    input  logic              clock,
    input  logic              reset,
    lifo_arb_if.slave         bus,
    output logic              lifo_write,
    output logic [DATA_W-1:0] lifo_datain,
    output logic              lifo_read,
    input  logic [DATA_W-1:0] lifo_dataout
`ifdef LIFO_ARB_STATS_EN
    ,
    output logic [15:0]       stat_push,
    output logic [15:0]       stat_pop,
    output logic [15:0]       stat_stall
`endif
);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t              state, state_nx;
    logic [CNT_W-1:0]    count_q;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     win;
    logic                found;
    logic                push_gnt, pop_gnt;
    logic [NUM_REQ-1:0]  push_ok, pop_ok;
    logic [NUM_REQ-1:0]  gnt;
    logic                fdone;
    logic                full_w, empty_w;
    logic                rsp_valid_q;
    logic [ID_W-1:0]     rsp_id_q;
    logic [DATA_W-1:0]   rsp_data_q;

    assign full_w         = (count_q == CNT_W'(LIFO_SIZE));
    assign empty_w        = (count_q == '0);
    assign bus.count      = count_q;
    assign bus.full       = full_w;
    assign bus.empty      = empty_w;
    assign bus.grant      = gnt;
    assign bus.flush_done = fdone;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_data   = rsp_data_q;

    // Per-requester eligibility; pop takes precedence inside a requester later.
    always_comb begin
        push_ok = '0;
        pop_ok  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            push_ok[i] = bus.req_push[i] && !full_w;
            pop_ok[i]  = bus.req_pop[i]  && !empty_w;
        end
    end

    // Round-robin search starting at rr_ptr, ascending with wrap.
    always_comb begin
        int idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && (push_ok[idx] || pop_ok[idx])) begin
                found = 1'b1;
                win   = ID_W'(idx);
            end
        end
    end

    // Next state and per-cycle stack strobes; flush beats any request.
    always_comb begin
        state_nx    = state;
        gnt         = '0;
        lifo_write  = 1'b0;
        lifo_read   = 1'b0;
        lifo_datain = '0;
        push_gnt    = 1'b0;
        pop_gnt     = 1'b0;
        fdone       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.flush) begin
                    state_nx = FLUSH;
                end else if (found) begin
                    gnt[win] = 1'b1;
                    if (pop_ok[win]) begin
                        pop_gnt   = 1'b1;
                        lifo_read = 1'b1;
                    end else begin
                        push_gnt    = 1'b1;
                        lifo_write  = 1'b1;
                        lifo_datain = bus.req_data[win*DATA_W +: DATA_W];
                    end
                end
            end
            FLUSH: begin
                if (!empty_w) begin
                    lifo_read = 1'b1;
                end else begin
                    fdone    = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, occupancy and round-robin pointer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            count_q <= '0;
            rr_ptr  <= '0;
        end else begin
            state <= state_nx;
            if (push_gnt)
                count_q <= count_q + 1'b1;
            else if (lifo_read)
                count_q <= count_q - 1'b1;
            if (push_gnt || pop_gnt)
                rr_ptr <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
        end
    end

    // Pop response: capture top-of-stack and winner id, valid for one cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= pop_gnt;
            if (pop_gnt) begin
                rsp_id_q   <= win;
                rsp_data_q <= lifo_dataout;
            end
        end
    end

`ifdef LIFO_ARB_STATS_EN
    // Saturating activity counters; stalls count IDLE cycles with requests but no grant.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_push  <= '0;
            stat_pop   <= '0;
            stat_stall <= '0;
        end else begin
            if (push_gnt && stat_push != 16'hFFFF)
                stat_push <= stat_push + 1'b1;
            if (pop_gnt && stat_pop != 16'hFFFF)
                stat_pop <= stat_pop + 1'b1;
            if (state == IDLE && (|bus.req_push || |bus.req_pop) && gnt == '0
                && stat_stall != 16'hFFFF)
                stat_stall <= stat_stall + 1'b1;
        end
    end
`endif

endmodule

// File: doc/lifo_arb.md
Name: lifo_arb

Overview:
- Shares one LIFO stack between NUM_REQ requesters.
- Round-robin arbitration of push/pop requests, one stack operation per cycle.
- Tracks occupancy so pushes are never issued to a full stack and pops never to an empty one.
- Returns pop data to the winning requester, tagged by id; also supports a flush sequence that drains the stack.
- Sits between requester logic and the lifo stack instance, driving its write/datain/read and sampling its dataout.

Parameters:
- DATA_W, 10, data word width.
- LIFO_SIZE, 6, stack depth in entries; must match the attached stack.
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester id width; must satisfy 2**ID_W >= NUM_REQ.
- CNT_W, 4, occupancy counter width; must satisfy 2**CNT_W > LIFO_SIZE.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_push  in  NUM_REQ  per-requester push request; held until granted.
- req_pop  in  NUM_REQ  per-requester pop request; held until granted.
- req_data  in  NUM_REQ*DATA_W  push data; requester i occupies bits [i*DATA_W +: DATA_W].
- grant  out  NUM_REQ  one-hot grant, combinational, same cycle as the operation.
- flush  in  1  single-cycle pulse; start draining the stack.
- flush_done  out  1  single-cycle pulse; flush finished.
- lifo_write  out  1  stack write strobe.
- lifo_datain  out  DATA_W  stack write data.
- lifo_read  out  1  stack read (pop) strobe.
- lifo_dataout  in  DATA_W  stack top-of-stack data, combinational.
- rsp_valid  out  1  pop data valid, one cycle after the pop grant.
- rsp_id  out  ID_W  requester that issued the pop.
- rsp_data  out  DATA_W  popped word.
- count  out  CNT_W  current occupancy.
- full  out  1  high when count == LIFO_SIZE.
- empty  out  1  high when count == 0.

Behaviour:
- Reset values: state=IDLE, count=0, rr_ptr=0, rsp_valid=0, rsp_id=0, rsp_data=0, flush_done=0. Consequently full=0, empty=1, and grant, lifo_write and lifo_read are all 0.
- FSM states:
  - IDLE: arbitrate.
  - FLUSH: drain the stack.
  - IDLE->FLUSH on flush=1. This takes priority over all requests; no grant is issued that cycle.
  - FLUSH->IDLE when count==0 at the clock edge. In that cycle flush_done=1.
- FLUSH with an empty stack: flush_done is asserted the cycle after the flush pulse.
- Eligibility of requester i in IDLE:
  - push_ok = req_push[i] and not full.
  - pop_ok = req_pop[i] and not empty.
  - If both req_push[i] and req_pop[i] are set, the pop is performed; the push stays pending.
  - A requester is eligible if push_ok or pop_ok.
- Arbitration:
  - Search eligible requesters starting at rr_ptr, ascending with wrap; the first one found wins.
  - On a grant, rr_ptr <= winner+1 (mod NUM_REQ). With no grant, rr_ptr holds.
- Push grant: lifo_write=1, lifo_datain=winner's req_data, count <= count+1.
- Pop grant: lifo_read=1.
  - Register lifo_dataout into rsp_data and the winner id into rsp_id.
  - rsp_valid=1 on the next cycle; count <= count-1.
- rsp_valid lasts exactly one cycle and has no back-pressure.
- lifo_write and lifo_read are never both high.
- FLUSH: lifo_read=1 every cycle while count>0. count decrements, grant=0, rsp_valid=0, and requests are ignored (they stay pending).
- Counting: count never exceeds LIFO_SIZE and never underflows.
  - A push request while full is not granted; it waits.
  - A pop request while empty is not granted; it waits.
- A flush pulse arriving while already in FLUSH is ignored.
- Reset asserted mid-operation returns everything to reset values immediately (asynchronous). In-flight rsp_valid is dropped.

Optional Feature:
- Macro: LIFO_ARB_STATS_EN.
- Defined: adds three output ports, all 16-bit saturating counters, cleared by reset.
  - stat_push: granted pushes.
  - stat_pop: granted pops; flush pops excluded.
  - stat_stall: IDLE cycles with at least one request pending but no grant.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset; req0 pushes 0x011, then 0x022, then pops → count goes 1, 2, 1; one cycle after the pop grant rsp_valid=1, rsp_id=0, rsp_data=0x022.
- req0..req3 all hold push from rr_ptr=0 → grants issued in order 0,1,2,3, one per cycle; count=4.
- Push until count=6 (full=1), then req1 pushes → no grant, lifo_write=0 while full; a pop by req2 then lets req1's push proceed, count=6 again.
- Stack holding 3 entries, flush pulse while req0 requests a pop → lifo_read high for 3 cycles with no grant, flush_done pulse, count=0; req0's pop is then held (empty).
- Same requester asserts push and pop with count=2 → pop is granted; push is granted afterwards; count ends at 2.
- Assert reset mid-flush at count=2 → count=0, state=IDLE, rsp_valid=0 immediately, without waiting for a clock edge.
